// File: rtl/bk_pkg.sv
// Shared helpers for the pipelined Brent-Kung adder: prefix operator,
// elaboration-time log2 and pipeline-boundary placement.
package bk_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Brent-Kung prefix operator: (gh,ph) o (gl,pl)
    function automatic logic [1:0] pg_combine(input logic gh, input logic ph,
                                              input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    function automatic int unsigned bk_levels(input int unsigned width);
        return 2 * clog2(width) - 1;
    endfunction

    function automatic int unsigned boundary_level(input int unsigned k,
                                                   input int unsigned total,
                                                   input int unsigned stages);
        return (k * total + stages - 1) / stages;
    endfunction

    function automatic logic is_boundary(input int unsigned lvl,
                                         input int unsigned total,
                                         input int unsigned stages);
        for (int unsigned k = 1; k <= stages; k++) begin
            if (boundary_level(k, total, stages) == lvl) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One combinational Brent-Kung prefix level: levels below log2(WIDTH) form
// the up-sweep, the remaining ones the down-sweep.
module bk_prefix_level
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEVEL = 0
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);

    localparam int unsigned LG   = clog2(WIDTH);
    localparam logic        UP   = (LEVEL < LG);
    localparam int unsigned D    = UP ? LEVEL : (2 * LG - 2 - LEVEL);
    localparam int unsigned SPAN = 32'd1 << D;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Up-sweep combines at the top of each 2*SPAN block; down-sweep fills
        // the midpoints of blocks from the completed lower prefix.
        localparam logic COMB = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                   : ((((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) >= 3 * SPAN));
        if (COMB) begin : g_op
            assign {g_o[i], p_o[i]} = pg_combine(g_i[i], p_i[i], g_i[i-SPAN], p_i[i-SPAN]);
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with global-stall valid/ready control.
// Logic levels: pg generation, LEVELS prefix levels, carry/sum XOR.
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LEVELS = bk_levels(WIDTH);
    localparam int unsigned NODES  = LEVELS + 2;

    logic              advance;
    logic [STAGES:1]   vld_q;
    logic [STAGES:1]   vld_d;

    // Node j is the value after logic level j, either wired or registered.
    logic [WIDTH-1:0]  g_c  [1:NODES-1];
    logic [WIDTH-1:0]  p_c  [1:NODES-1];
    logic [WIDTH-1:0]  h_c  [1:NODES-1];
    logic              c0_c [1:NODES-1];
    logic [WIDTH-1:0]  g_n  [1:NODES-1];
    logic [WIDTH-1:0]  p_n  [1:NODES-1];
    logic [WIDTH-1:0]  h_n  [1:NODES-1];
    logic              c0_n [1:NODES-1];

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum_d, sum_q;
    logic              cout_d, cout_q;
    logic              ovf_d, ovf_q;

    assign out_valid = vld_q[STAGES];
    assign advance   = !vld_q[STAGES] | out_ready;
    assign in_ready  = advance;

    always_comb begin
        vld_d = vld_q;
        if (advance) begin
            vld_d[1] = in_valid;
            for (int unsigned k = 2; k <= STAGES; k++) vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign b_eff   = sub ? ~b : b;
    assign g_c[1]  = a & b_eff;
    assign p_c[1]  = a ^ b_eff;
    assign h_c[1]  = a ^ b_eff;
    assign c0_c[1] = sub ? ~cin : cin;

    for (genvar j = 2; j <= NODES - 1; j++) begin : g_lvl
        bk_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (j - 2)
        ) u_lvl (
            .g_i (g_n[j-1]),
            .p_i (p_n[j-1]),
            .g_o (g_c[j]),
            .p_o (p_c[j])
        );
        assign h_c[j]  = h_n[j-1];
        assign c0_c[j] = c0_n[j-1];
    end

    for (genvar j = 1; j <= NODES - 1; j++) begin : g_node
        if (is_boundary(j, NODES, STAGES)) begin : g_reg
            logic [WIDTH-1:0] g_q, p_q, h_q;
            logic             c0_q;
            always_ff @(posedge clk) begin
                if (advance) begin
                    g_q  <= g_c[j];
                    p_q  <= p_c[j];
                    h_q  <= h_c[j];
                    c0_q <= c0_c[j];
                end
            end
            assign g_n[j]  = g_q;
            assign p_n[j]  = p_q;
            assign h_n[j]  = h_q;
            assign c0_n[j] = c0_q;
        end else begin : g_wire
            assign g_n[j]  = g_c[j];
            assign p_n[j]  = p_c[j];
            assign h_n[j]  = h_c[j];
            assign c0_n[j] = c0_c[j];
        end
    end

    // Carry-in is applied after the prefix tree, so bit 0 stays a plain pg pair.
    always_comb begin
        carry    = '0;
        carry[0] = c0_n[NODES-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            carry[i] = g_n[NODES-1][i-1] | (p_n[NODES-1][i-1] & c0_n[NODES-1]);
        end
        sum_d  = h_n[NODES-1] ^ carry;
        cout_d = g_n[NODES-1][WIDTH-1] | (p_n[NODES-1][WIDTH-1] & c0_n[NODES-1]);
        ovf_d  = carry[WIDTH-1] ^ cout_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
